cpstr_man_rx: RTL and testbench
===============================

CPSTR_MAN_RX -- requirements
Module: cpstr_man_rx

Interface
REQ-001 SHALL have parameter NUM_STREAMS, default 3, number of output byte streams; legal range 1..27.
REQ-002 SHALL have parameter ESC_CHAR, default 8'd27, escape byte value.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_data  input  8  muxed input byte.
REQ-006 SHALL have port i_valid  input  1  input byte valid.
REQ-007 SHALL have port o_ready  output  1  input byte accepted when i_valid && o_ready.
REQ-008 SHALL have port o_data  output  8*NUM_STREAMS  per-stream data, stream k on bits [8k +: 8].
REQ-009 SHALL have port o_valid  output  NUM_STREAMS  per-stream valid, at most one bit set.
REQ-010 SHALL have port i_ready  input  NUM_STREAMS  per-stream sink ready.
REQ-011 SHALL have port o_stridx  output  8  currently selected stream index.
REQ-012 SHALL have port o_stridx_valid  output  1  a stream is currently selected.
REQ-013 SHALL have port o_err  output  1  one-cycle protocol error pulse.

Function
REQ-014 Input protocol: plain byte != ESC_CHAR = data for selected stream; ESC_CHAR,ESC_CHAR = literal ESC_CHAR data byte; ESC_CHAR,k with k < NUM_STREAMS = select stream k; ESC_CHAR,other = error.
REQ-015 Parser FSM SHALL have two states: S_DATA (normal) and S_ESC (escape seen); only accepted bytes advance it.
REQ-016 S_DATA + ESC_CHAR -> S_ESC, no output; S_DATA + other byte -> data byte, stay S_DATA.
REQ-017 S_ESC + ESC_CHAR -> data byte 0x1B, go S_DATA; S_ESC + k < NUM_STREAMS -> o_stridx<=k, o_stridx_valid<=1, go S_DATA.
REQ-018 S_ESC + any other byte -> byte dropped, o_err pulses next cycle, selection unchanged, go S_DATA.
REQ-019 Re-selecting the already-selected index SHALL be legal and silent (no error, no output).
REQ-020 Data byte while o_stridx_valid=0 SHALL be dropped with o_err pulse.
REQ-021 Output path: single holding register {hold_data, hold_idx, hold_valid}; o_valid[hold_idx]=hold_valid, o_data of every lane = hold_data (only the valid lane is meaningful).
REQ-022 o_ready SHALL equal !hold_valid || i_ready[hold_idx] (combinational from i_ready), for all byte types.
REQ-023 Data byte accepted in cycle N SHALL appear on o_valid in cycle N+1; back-to-back bytes to a ready sink SHALL sustain one byte per clock.
REQ-024 hold_valid SHALL clear on sink handshake unless a new data byte loads in the same cycle (load wins).
REQ-025 hold_idx SHALL be captured at load, so a stream switch while a byte is pending does not redirect that byte.
REQ-026 Stalled sink: hold register and o_valid/o_data SHALL stay stable until i_ready[hold_idx]; other lanes' i_ready ignored.
REQ-027 o_stridx SHALL be 8 bits, upper bits zero-extended from index.

Reset
REQ-028 On i_rst_n low (async): FSM=S_DATA, hold_valid=0, o_valid=0, o_data=0, o_stridx=0, o_stridx_valid=0, o_err=0; o_ready=1 after release.
REQ-029 Reset mid-escape or with a pending output byte SHALL discard both; first post-reset byte is parsed in S_DATA.

Verification
REQ-030 Stream 1B 00 10 11 12, all sinks ready -> o_stridx=0 valid, lane 0 gets 10,11,12 on consecutive cycles, no o_err.
REQ-031 Stream 1B 01 1B 1B 05 -> lane 1 gets 1B then 05; no error.
REQ-032 Stream 1B 02 AA with i_ready[2]=0 for 5 cycles, next byte BB -> o_valid[2]/AA held 5 cycles, o_ready=0, BB delivered cycle after AA handshake.
REQ-033 Stream 1B 00 11 1B 02 22 with i_ready[0] low during switch -> 11 stays on lane 0, 22 on lane 2 after 11 drains.
REQ-034 After reset send 55 then 1B 07 (NUM_STREAMS=3) -> two o_err pulses, no o_valid, o_stridx_valid=0.
REQ-035 Assert i_rst_n=0 after 1B 01 1B (escape pending) -> all outputs reset; then 1B 00 -> o_stridx=0, no stray data.

Source files
------------

// File: rtl/cpstr_man_rx.sv
// cpstr_man_rx : escape-coded stream demultiplexer.
//
// A single muxed byte stream carries data for up to NUM_STREAMS output lanes.
// An escape byte followed by a small index selects the active lane; a doubled
// escape byte is a literal escape data byte. Every other non-escape byte is
// data for the currently selected lane. Output bytes go through one holding
// register, so at most one lane is valid at a time.
//
// Ports
//   i_clk           single clock, all logic on the rising edge
//   i_rst_n         asynchronous active-low reset
//   i_data/i_valid  muxed input byte; accepted when i_valid && o_ready
//   o_ready         combinational: holding register empty or its sink ready
//   o_data          hold_data replicated on every lane (lane k = [8k +: 8])
//   o_valid         one-hot (or zero) valid for the lane the held byte targets
//   i_ready         per-lane sink ready
//   o_stridx        currently selected lane, zero-extended to 8 bits
//   o_stridx_valid  a lane has been selected since reset
//   o_err           one-cycle pulse after a bad escape or an unrouted data byte
//
// Parser states
//   state  | meaning
//   S_DATA | normal: bytes are data, or ESC_CHAR starts an escape
//   S_ESC  | escape seen: next byte is literal ESC_CHAR or a lane index

module cpstr_man_rx #(
  parameter int         NUM_STREAMS = 3,
  parameter logic [7:0] ESC_CHAR    = 8'd27
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [7:0]               i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [8*NUM_STREAMS-1:0] o_data,
  output logic [NUM_STREAMS-1:0]   o_valid,
  input  logic [NUM_STREAMS-1:0]   i_ready,
  output logic [7:0]               o_stridx,
  output logic                     o_stridx_valid,
  output logic                     o_err
);

  localparam int         IDX_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam logic [7:0] NUM_B = 8'(NUM_STREAMS);

  typedef enum logic {
    S_DATA = 1'b0,
    S_ESC  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             accept;
  logic             is_esc;
  logic             is_sel;

  logic             load;
  logic             sel_load;
  logic             err_set;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;

  logic [7:0]       hold_data;
  logic [IDX_W-1:0] hold_idx;
  logic             hold_valid;

  // Backpressure looks only at the sink of the byte currently held.
  assign o_ready = !hold_valid || i_ready[hold_idx];
  assign accept  = i_valid && o_ready;
  assign is_esc  = (i_data == ESC_CHAR);
  assign is_sel  = (i_data < NUM_B);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_DATA;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        S_DATA:  state_nxt = is_esc ? S_ESC : S_DATA;
        S_ESC:   state_nxt = S_DATA;
        default: state_nxt = S_DATA;
      endcase
    end
  end

  // A data byte, literal or plain, is only routable once a lane is selected.
  // The literal escape is i_data itself, so the load path never muxes data.
  always_comb begin
    load     = 1'b0;
    sel_load = 1'b0;
    err_set  = 1'b0;
    if (accept) begin
      case (state)
        S_DATA: begin
          if (!is_esc) begin
            load    = sel_valid;
            err_set = !sel_valid;
          end
        end
        S_ESC: begin
          if (is_esc) begin
            load    = sel_valid;
            err_set = !sel_valid;
          end else if (is_sel) begin
            sel_load = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
        default: begin
          load     = 1'b0;
          sel_load = 1'b0;
          err_set  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_idx   <= '0;
      sel_valid <= 1'b0;
    end else if (sel_load) begin
      sel_idx   <= i_data[IDX_W-1:0];
      sel_valid <= 1'b1;
    end
  end

  // hold_idx is latched with the byte so a later lane switch cannot redirect
  // a byte still waiting on a stalled sink. A new load wins over a drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_data  <= 8'd0;
      hold_idx   <= '0;
      hold_valid <= 1'b0;
    end else if (load) begin
      hold_data  <= i_data;
      hold_idx   <= sel_idx;
      hold_valid <= 1'b1;
    end else if (hold_valid && i_ready[hold_idx]) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err <= 1'b0;
    end else begin
      o_err <= err_set;
    end
  end

  always_comb begin
    o_valid = '0;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      o_valid[k] = hold_valid && (hold_idx == IDX_W'(k));
    end
  end

  assign o_data         = {NUM_STREAMS{hold_data}};
  assign o_stridx       = {{(8-IDX_W){1'b0}}, sel_idx};
  assign o_stridx_valid = sel_valid;

endmodule

// File: tb/tb_cpstr_man_rx.sv
module tb_cpstr_man_rx;

  localparam int         N   = 3;
  localparam logic [7:0] ESC = 8'h1B;

  logic           i_clk;
  logic           i_rst_n;
  logic [7:0]     i_data;
  logic           i_valid;
  logic           o_ready;
  logic [8*N-1:0] o_data;
  logic [N-1:0]   o_valid;
  logic [N-1:0]   i_ready;
  logic [7:0]     o_stridx;
  logic           o_stridx_valid;
  logic           o_err;

  cpstr_man_rx #(.NUM_STREAMS(N), .ESC_CHAR(ESC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_stridx(o_stridx), .o_stridx_valid(o_stridx_valid), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int ncmp = 0;
  int nfail = 0;
  logic [31:0] cyc = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic [7:0]  lane;
    logic [7:0]  d;
    logic [31:0] cyc;
  } dlv_t;
  dlv_t dq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: escape pending flag, current selection, one held byte.
  logic       m_esc;
  logic       m_selv;
  int         m_sel;
  logic       m_hv;
  logic [7:0] m_hd;
  int         m_hi;
  logic       m_err;

  always @(posedge i_clk or negedge i_rst_n) begin
    logic rdy, acc, ld, e;
    logic [7:0] b;
    if (!i_rst_n) begin
      m_esc = 0; m_selv = 0; m_sel = 0; m_hv = 0; m_hd = 0; m_hi = 0; m_err = 0;
    end else begin
      rdy = !m_hv || i_ready[m_hi];
      acc = i_valid && rdy;
      b = i_data;
      ld = 0; e = 0;
      if (acc) begin
        if (m_esc) begin
          m_esc = 0;
          if (b == ESC) ld = 1;
          else if (int'(b) < N) begin m_sel = int'(b); m_selv = 1; end
          else e = 1;
        end else if (b == ESC) begin
          m_esc = 1;
        end else begin
          ld = 1;
        end
        if (ld && !m_selv) begin ld = 0; e = 1; end
      end
      if (ld) begin m_hv = 1; m_hd = b; m_hi = m_sel; end
      else if (rdy) m_hv = 0;
      m_err = e;
    end
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  // Per-cycle compare against the model, plus delivery/error logging.
  always @(negedge i_clk) begin
    logic [N-1:0]   ev;
    logic [8*N-1:0] ed;
    dlv_t t;
    ev = '0;
    if (m_hv) ev[m_hi] = 1'b1;
    ed = {N{m_hd}};
    chk("o_ready", 32'(o_ready), 32'(!m_hv || i_ready[m_hi]));
    chk("o_valid", 32'(o_valid), 32'(ev));
    chk("o_data", 32'(o_data), 32'(ed));
    chk("o_stridx", 32'(o_stridx), 32'(m_sel));
    chk("o_stridx_valid", 32'(o_stridx_valid), 32'(m_selv));
    chk("o_err", 32'(o_err), 32'(m_err));
    if (o_err) err_cnt++;
    for (int k = 0; k < N; k++) begin
      if (o_valid[k] && i_ready[k]) begin
        t.lane = 8'(k);
        t.d = o_data[8*k +: 8];
        t.cyc = cyc;
        dq.push_back(t);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    logic acc;
    i_data = b; i_valid = 1'b1; n = 0; acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk); #1;
      n++;
    end
    if (!acc) begin
      ncmp++; nfail++;
      $display("FAIL send_timeout: byte %0h not accepted, required within 50 cycles", b);
    end
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic do_reset();
    i_valid = 1'b0; i_data = 8'h00; i_ready = '1;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    dq.delete(); err_cnt = 0;
  endtask

  initial begin
    i_rst_n = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_ready = '1;
    #2 i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("rst_o_valid", 32'(o_valid), 0);
    chk("rst_o_data", 32'(o_data), 0);
    chk("rst_o_stridx_valid", 32'(o_stridx_valid), 0);
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_o_ready", 32'(o_ready), 1);

    // Lane 0 gets three consecutive bytes.
    do_reset();
    send(ESC); send(8'h00); send(8'h10); send(8'h11); send(8'h12);
    idle(4);
    chk("t1_count", dq.size(), 3);
    chk("t1_b0", {dq[0].lane, dq[0].d}, 32'h0010);
    chk("t1_b1", {dq[1].lane, dq[1].d}, 32'h0011);
    chk("t1_b2", {dq[2].lane, dq[2].d}, 32'h0012);
    chk("t1_gap1", dq[1].cyc - dq[0].cyc, 1);
    chk("t1_gap2", dq[2].cyc - dq[1].cyc, 1);
    chk("t1_stridx", {o_stridx_valid, o_stridx}, 32'h100);
    chk("t1_err", err_cnt, 0);

    // Literal escape on lane 1.
    do_reset();
    send(ESC); send(8'h01); send(ESC); send(ESC); send(8'h05);
    idle(4);
    chk("t2_count", dq.size(), 2);
    chk("t2_b0", {dq[0].lane, dq[0].d}, 32'h011B);
    chk("t2_b1", {dq[1].lane, dq[1].d}, 32'h0105);
    chk("t2_err", err_cnt, 0);

    // Stalled lane 2 holds AA for 5 cycles while BB waits.
    do_reset();
    i_ready = 3'b011;
    send(ESC); send(8'h02); send(8'hAA);
    i_data = 8'hBB; i_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge i_clk);
      chk("t3_hold_valid", 32'(o_valid), 32'h4);
      chk("t3_hold_data", 32'(o_data[23:16]), 32'hAA);
      chk("t3_ready_low", 32'(o_ready), 0);
      @(posedge i_clk); #1;
    end
    i_ready = 3'b111;
    send(8'hBB);
    idle(3);
    chk("t3_count", dq.size(), 2);
    chk("t3_b0", {dq[0].lane, dq[0].d}, 32'h02AA);
    chk("t3_b1", {dq[1].lane, dq[1].d}, 32'h02BB);
    chk("t3_gap", dq[1].cyc - dq[0].cyc, 1);

    // Lane switch while a byte is pending on a stalled lane 0.
    do_reset();
    send(ESC); send(8'h00);
    i_ready = 3'b110;
    send(8'h11);
    fork
      begin send(ESC); send(8'h02); send(8'h22); end
      begin repeat (4) @(posedge i_clk); #1 i_ready = 3'b111; end
    join
    idle(3);
    chk("t4_count", dq.size(), 2);
    chk("t4_b0", {dq[0].lane, dq[0].d}, 32'h0011);
    chk("t4_b1", {dq[1].lane, dq[1].d}, 32'h0222);
    chk("t4_order", 32'(dq[1].cyc > dq[0].cyc), 1);

    // Errors: unrouted data and out-of-range index.
    do_reset();
    send(8'h55); send(ESC); send(8'h07);
    idle(3);
    chk("t5_err", err_cnt, 2);
    chk("t5_count", dq.size(), 0);
    chk("t5_stridx_valid", 32'(o_stridx_valid), 0);

    // Reset with an escape pending.
    do_reset();
    send(ESC); send(8'h01); send(ESC);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("t6_rst_outs", {o_valid, o_data, o_stridx, o_stridx_valid, o_err}, 0);
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    dq.delete(); err_cnt = 0;
    @(negedge i_clk);
    chk("t6_ready", 32'(o_ready), 1);
    @(posedge i_clk); #1;
    send(ESC); send(8'h00);
    idle(3);
    chk("t6_stridx", {o_stridx_valid, o_stridx}, 32'h100);
    chk("t6_count", dq.size(), 0);
    chk("t6_err", err_cnt, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) i_data = ESC;
      else if (r < 7) i_data = 8'($urandom_range(0, 3));
      else i_data = 8'($urandom_range(0, 255));
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'($urandom_range(0, 7));
      i_rst_n = ($urandom_range(0, 299) != 0);
      @(posedge i_clk); #1;
    end
    i_rst_n = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
